// File: rtl/exec_pkg.sv
// Shared types for the execution sequencer: FSM states, instruction field
// layout and sticky error codes.
package exec_pkg;

    localparam int INSTR_W   = 24;
    localparam int OPR_LSB   = 0;
    localparam int OPR_W     = 5;
    localparam int SEL_W     = 4;
    localparam int SRCA_LSB  = 5;
    localparam int SRCB_LSB  = 9;
    localparam int DST_LSB   = 13;
    localparam int CNSTA_BIT = 17;
    localparam int CNSTB_BIT = 18;
    localparam int ENDW_LSB  = 19;
    localparam int ENDW_W    = 2;
    localparam int WBEN_BIT  = 21;
    localparam int RSVD_LSB  = 22;
    localparam int RSVD_W    = 2;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        EXEC,
        WAIT,
        WB
    } state_e;

    // Fields still needed after the handshake cycle.
    typedef struct packed {
        logic              wb_en;
        logic [ENDW_W-1:0] endw;
        logic [SEL_W-1:0]  dst;
        logic [OPR_W-1:0]  opr;
    } instr_hold_t;

    function automatic instr_hold_t hold_fields(input logic [INSTR_W-1:0] w);
        instr_hold_t h;
        h.wb_en = w[WBEN_BIT];
        h.endw  = w[ENDW_LSB +: ENDW_W];
        h.dst   = w[DST_LSB +: SEL_W];
        h.opr   = w[OPR_LSB +: OPR_W];
        return h;
    endfunction

    function automatic logic reserved_set(input logic [INSTR_W-1:0] w);
        return |w[RSVD_LSB +: RSVD_W];
    endfunction

endpackage

// File: rtl/done_watchdog.sv
// Counts WAIT cycles since the last clear; expired flags the last cycle in
// which a missing ALU completion is still tolerated.
module done_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/exec_ctrl.sv
// Single-issue sequencer: instruction handshake, bank read, operand latch,
// ALU start/wait with watchdog, and optional write-back.
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_ready is high exactly while state is IDLE.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic [SEL_W-1:0]     seloutA,
    output logic [SEL_W-1:0]     seloutB,
    output logic                 cnstA,
    output logic                 cnstB,
    output logic                 enrregA,
    output logic                 enrregB,
    input  logic [DATA_W-1:0]    banq_outA,
    input  logic [DATA_W-1:0]    banq_outB,
    output logic [DATA_W-1:0]    aluA,
    output logic [DATA_W-1:0]    aluB,
    output logic [OPR_W-1:0]     opr,
    output logic                 start,
    input  logic                 alu_done,
    input  logic [DATA_W-1:0]    alu_out,
    output logic                 regwen,
    output logic [SEL_W-1:0]     selwreg,
    output logic [ENDW_W-1:0]    endwreg,
    output logic [DATA_W-1:0]    wdata,
    output logic                 busy,
    output logic [1:0]           err,
    output state_e               dbg_state
);

    state_e            state_q, state_d;
    instr_hold_t       hold_q, hold_d;
    logic              instr_ready_q, instr_ready_d;
    logic              busy_q, busy_d;
    logic [SEL_W-1:0]  sela_q, sela_d, selb_q, selb_d;
    logic              cnsta_q, cnsta_d, cnstb_q, cnstb_d;
    logic              enra_q, enra_d, enrb_q, enrb_d;
    logic [DATA_W-1:0] alua_q, alua_d, alub_q, alub_d;
    logic [OPR_W-1:0]  opr_q, opr_d;
    logic              start_q, start_d;
    logic              regwen_q, regwen_d;
    logic [SEL_W-1:0]  selw_q, selw_d;
    logic [ENDW_W-1:0] endw_q, endw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        err_q, err_d;
    logic              wd_clear, wd_en, wd_expired;

    done_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_en),
        .expired(wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        sela_d   = sela_q;
        selb_d   = selb_q;
        cnsta_d  = cnsta_q;
        cnstb_d  = cnstb_q;
        alua_d   = alua_q;
        alub_d   = alub_q;
        opr_d    = opr_q;
        selw_d   = selw_q;
        endw_d   = endw_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        enra_d   = 1'b0;
        enrb_d   = 1'b0;
        start_d  = 1'b0;
        regwen_d = 1'b0;
        wd_clear = 1'b0;
        wd_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    hold_d = hold_fields(instr);
                    if (reserved_set(instr)) begin
                        err_d = ERR_ILLEGAL;
                    end else begin
                        err_d   = ERR_NONE;
                        state_d = READ;
                        sela_d  = instr[SRCA_LSB +: SEL_W];
                        selb_d  = instr[SRCB_LSB +: SEL_W];
                        cnsta_d = instr[CNSTA_BIT];
                        cnstb_d = instr[CNSTB_BIT];
                        enra_d  = 1'b1;
                        enrb_d  = 1'b1;
                    end
                end
            end
            READ: begin
                opr_d   = hold_q.opr;
                state_d = LATCH;
            end
            LATCH: begin
                // Bank data arrives the cycle after the read enable.
                alua_d  = banq_outA;
                alub_d  = banq_outB;
                start_d = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                wd_clear = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                wd_en = 1'b1;
                if (alu_done) begin
                    wdata_d = alu_out;
                    if (hold_q.wb_en) begin
                        state_d  = WB;
                        regwen_d = 1'b1;
                        selw_d   = hold_q.dst;
                        endw_d   = hold_q.endw;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wd_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = IDLE;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        instr_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            sela_q        <= '0;
            selb_q        <= '0;
            cnsta_q       <= 1'b0;
            cnstb_q       <= 1'b0;
            enra_q        <= 1'b0;
            enrb_q        <= 1'b0;
            alua_q        <= '0;
            alub_q        <= '0;
            opr_q         <= '0;
            start_q       <= 1'b0;
            regwen_q      <= 1'b0;
            selw_q        <= '0;
            endw_q        <= '0;
            wdata_q       <= '0;
            err_q         <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            sela_q        <= sela_d;
            selb_q        <= selb_d;
            cnsta_q       <= cnsta_d;
            cnstb_q       <= cnstb_d;
            enra_q        <= enra_d;
            enrb_q        <= enrb_d;
            alua_q        <= alua_d;
            alub_q        <= alub_d;
            opr_q         <= opr_d;
            start_q       <= start_d;
            regwen_q      <= regwen_d;
            selw_q        <= selw_d;
            endw_q        <= endw_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign busy        = busy_q;
    assign seloutA     = sela_q;
    assign seloutB     = selb_q;
    assign cnstA       = cnsta_q;
    assign cnstB       = cnstb_q;
    assign enrregA     = enra_q;
    assign enrregB     = enrb_q;
    assign aluA        = alua_q;
    assign aluB        = alub_q;
    assign opr         = opr_q;
    assign start       = start_q;
    assign regwen      = regwen_q;
    assign selwreg     = selw_q;
    assign endwreg     = endw_q;
    assign wdata       = wdata_q;
    assign err         = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: bank and sum-ALU models, directed timing scenarios,
// randomized instructions checked against a register-file reference model.
module tb_exec_ctrl;
    import exec_pkg::*;

    localparam int DATA_W = 64;
    localparam int TO     = 8;
    localparam int SB_W   = ENDW_W + SEL_W + DATA_W;
    localparam int M_OK    = 0;
    localparam int M_NEVER = 1;
    localparam int M_SPUR  = 2;

    logic              clock;
    logic              reset;
    logic [23:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        seloutA, seloutB;
    logic              cnstA, cnstB, enrregA, enrregB;
    logic [DATA_W-1:0] banq_outA, banq_outB;
    logic [DATA_W-1:0] aluA, aluB;
    logic [4:0]        opr;
    logic              start;
    logic              alu_done;
    logic [DATA_W-1:0] alu_out;
    logic              regwen;
    logic [3:0]        selwreg;
    logic [1:0]        endwreg;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic [1:0]        err;
    state_e            dbg_state;

    exec_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .seloutA(seloutA), .seloutB(seloutB),
        .cnstA(cnstA), .cnstB(cnstB), .enrregA(enrregA), .enrregB(enrregB),
        .banq_outA(banq_outA), .banq_outB(banq_outB), .aluA(aluA), .aluB(aluB),
        .opr(opr), .start(start), .alu_done(alu_done), .alu_out(alu_out),
        .regwen(regwen), .selwreg(selwreg), .endwreg(endwreg), .wdata(wdata),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic [SB_W-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- bank model ----------------
    logic [DATA_W-1:0] bank [16];
    logic [DATA_W-1:0] init_regs [16];
    logic [DATA_W-1:0] ref_regs [16];

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) bank[i] <= init_regs[i];
            banq_outA <= '0;
            banq_outB <= '0;
        end else begin
            if (enrregA) banq_outA <= bank[seloutA];
            if (enrregB) banq_outB <= bank[seloutB];
            if (regwen) bank[selwreg] <= wdata;
        end
    end

    // ---------------- ALU model: sum, done lat cycles after start ----------------
    int alu_mode = M_OK;
    int alu_lat  = 1;
    int due      = 0;
    bit pend     = 1'b0;
    logic [DATA_W-1:0] sum_r;

    initial alu_done = 1'b0;
    always @(negedge clock) begin
        alu_done = 1'b0;
        alu_out  = {$urandom(), $urandom()};
        if (reset && start) begin
            sum_r = aluA + aluB;
            pend  = (alu_mode != M_NEVER);
            due   = edge_cnt + ((alu_mode == M_SPUR) ? 0 : alu_lat);
        end
        if (pend && edge_cnt == due) begin
            alu_done = 1'b1;
            alu_out  = sum_r;
            pend     = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    logic regwen_prev = 1'b0, start_prev = 1'b0, enr_prev = 1'b0;
    always @(negedge clock) begin
        if (regwen === 1'b1) begin
            chk("regwen_width", regwen_prev, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL regwen_unexpected actual=sel%0d/%0h required=none", selwreg, wdata);
            end else begin
                chk("wb_data", {endwreg, selwreg, wdata}, exp_q.pop_front());
            end
        end
        if (start === 1'b1) chk("start_width", start_prev, 0);
        if (enrregA === 1'b1) chk("enr_width", enr_prev, 0);
        regwen_prev = (regwen === 1'b1);
        start_prev  = (start === 1'b1);
        enr_prev    = (enrregA === 1'b1);
    end

    // ---------------- driver tasks ----------------
    int hs_edge = 0;
    int exp_ready_cyc = 0;
    logic [1:0] exp_err = ERR_NONE;
    logic [DATA_W-1:0] last_sum = '0;

    function automatic int rel();
        return edge_cnt - hs_edge + 1;
    endfunction

    task automatic wait_cycle(input int k);
        while (rel() < k) @(negedge clock);
    endtask

    // Reference model: computes outcome from the instruction rules, then hands it in.
    task automatic issue(input logic [23:0] ins, input bit keep, input int mode, input int lat);
        logic [DATA_W-1:0] s;
        int n;
        if (ins[23:22] != 2'b00) begin
            exp_err = ERR_ILLEGAL;
            exp_ready_cyc = 1;
        end else if (mode != M_OK || lat > TO) begin
            exp_err = ERR_TIMEOUT;
            exp_ready_cyc = 4 + TO;
        end else begin
            s = ref_regs[ins[8:5]] + ref_regs[ins[12:9]];
            last_sum = s;
            exp_err = ERR_NONE;
            if (ins[21]) begin
                exp_q.push_back({ins[20:19], ins[16:13], s});
                ref_regs[ins[16:13]] = s;
                exp_ready_cyc = 3 + lat + 2;
            end else begin
                exp_ready_cyc = 3 + lat + 1;
            end
        end
        alu_mode = mode;
        alu_lat  = lat;
        instr = ins;
        instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (instr_ready !== 1'b1) chk("handshake_wait", instr_ready, 1);
        @(negedge clock);
        hs_edge = edge_cnt;
        if (!keep) instr_valid = 1'b0;
    endtask

    task automatic finish_check(input string tag);
        int n = 0;
        while (instr_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready_cyc"}, rel(), exp_ready_cyc);
        chk({tag, "_err"}, err, exp_err);
    endtask

    // ---------------- stimulus ----------------
    int h1, h2, h3;
    logic [23:0] ri;

    initial begin
        reset = 1'b0;
        instr = '0;
        instr_valid = 1'b0;
        for (int i = 0; i < 16; i++) init_regs[i] = {$urandom(), $urandom()};
        init_regs[1] = 64'h10;
        init_regs[2] = 64'h20;
        for (int i = 0; i < 16; i++) ref_regs[i] = init_regs[i];
        repeat (3) @(negedge clock);
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, ERR_NONE);
        chk("rst_wdata", wdata, 0);
        chk("rst_start_regwen", {start, regwen, enrregA, enrregB}, 0);
        reset = 1'b1;
        @(negedge clock);

        // Write-back sum with full timing.
        issue(24'h206422, 1'b0, M_OK, 2);
        chk("t1_c1_read", {enrregA, enrregB, seloutA, seloutB, busy, instr_ready}, {1'b1, 1'b1, 4'd1, 4'd2, 1'b1, 1'b0});
        wait_cycle(3);
        chk("t1_c3_start", start, 1);
        chk("t1_c3_ops", {aluA, aluB, opr}, {64'h10, 64'h20, 5'd2});
        wait_cycle(6);
        chk("t1_c6_wb", {regwen, selwreg, wdata}, {1'b1, 4'd3, 64'h30});
        finish_check("t1");

        // No write-back.
        issue(24'h006422, 1'b0, M_OK, 2);
        finish_check("t2");
        chk("t2_wdata", wdata, last_sum);
        chk("t2_wdata_const", wdata, 64'h30);

        // Illegal: reserved bits set.
        issue(24'hC06422, 1'b0, M_OK, 2);
        chk("t3_c1", {err, instr_ready, enrregA, busy}, {ERR_ILLEGAL, 1'b1, 1'b0, 1'b0});
        finish_check("t3");
        for (int k = 2; k <= 6; k++) begin
            wait_cycle(k);
            chk("t3_quiet", {start, regwen, enrregA, instr_ready}, 4'b0001);
        end

        // Timeout, with a done pulse during EXEC that must be ignored.
        issue(24'h206422, 1'b0, M_SPUR, 0);
        wait_cycle(TO + 3);
        chk("t4_still_busy", {instr_ready, busy}, 2'b01);
        finish_check("t4");
        issue(24'h206422, 1'b0, M_OK, 1);
        chk("t4_err_cleared", err, ERR_NONE);
        finish_check("t4b");

        // Done in the very last allowed cycle, then one cycle too late.
        issue(24'h20A422 | 24'h080000, 1'b0, M_OK, TO);
        finish_check("last_ok");
        issue(24'h20A422, 1'b0, M_OK, TO + 1);
        finish_check("too_late");

        // Reset during WAIT, late done afterwards.
        issue(24'h206422, 1'b0, M_OK, 3);
        wait_cycle(4);
        reset = 1'b0;
        wait_cycle(5);
        chk("rst_wait_state", dbg_state, IDLE);
        chk("rst_wait_ctl", {instr_ready, busy, start, regwen, enrregA, enrregB, cnstA, cnstB, err}, 10'b10_0000_0000);
        chk("rst_wait_data", {aluA, aluB, wdata, opr, seloutA, seloutB, selwreg, endwreg}, 0);
        reset = 1'b1;
        chk("sb_before_reset", exp_q.size(), 1);
        exp_q.delete();
        for (int i = 0; i < 16; i++) ref_regs[i] = init_regs[i];
        for (int k = 6; k <= 10; k++) begin
            wait_cycle(k);
            chk("rst_no_regwen", regwen, 0);
        end

        // Back-to-back with valid held high.
        issue(24'h206422, 1'b1, M_OK, 1);
        h1 = hs_edge;
        issue(24'h208422, 1'b1, M_OK, 1);
        h2 = hs_edge;
        issue(24'h20A422, 1'b0, M_OK, 1);
        h3 = hs_edge;
        finish_check("b2b");
        chk("b2b_gap1", h2 - h1, 6);
        chk("b2b_gap2", h3 - h2, 6);

        // Randomized instructions.
        for (int n = 0; n < 40; n++) begin
            int r, lat, mode;
            ri = $urandom();
            ri[23:22] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r = $urandom_range(0, 9);
            lat = (r < 7) ? 1 + (r % 4) : ((r == 7) ? TO : ((r == 8) ? TO + 1 : 2));
            mode = ($urandom_range(0, 9) == 0) ? M_NEVER : M_OK;
            issue(ri, 1'b0, mode, lat);
            if (ri[23:22] == 2'b00) begin
                chk("rnd_c1", {seloutA, seloutB, cnstA, cnstB, enrregA, enrregB},
                    {ri[8:5], ri[12:9], ri[17], ri[18], 1'b1, 1'b1});
                wait_cycle(3);
                chk("rnd_c3", {start, opr}, {1'b1, ri[4:0]});
            end else begin
                chk("rnd_illegal", {enrregA, err}, {1'b0, ERR_ILLEGAL});
            end
            finish_check("rnd");
        end

        repeat (10) @(negedge clock);
        chk("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Single-issue execution sequencer between the instruction source and the `reg_banq`/`alu` pair. It accepts one 24-bit instruction per valid/ready handshake and drives the register-bank read selects. It latches both operands, pulses `alu` start and waits for `done`. It then writes the 64-bit result back into the bank. A watchdog aborts an instruction whose ALU never completes.

## Interface
Parameters:
- `DATA_W`, 64: operand/result width.
- `TIMEOUT_CYCLES`, 64: max cycles in WAIT before abort (≥2).

Ports:
- `clock`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-low.
- `instr`  in  24: instruction word. Fields:
  - [4:0] opr
  - [8:5] srcA
  - [12:9] srcB
  - [16:13] dst
  - [17] cnstA
  - [18] cnstB
  - [20:19] endw
  - [21] wb_en
  - [23:22] reserved, must be 0
- `instr_valid`  in  1: instruction offered.
- `instr_ready`  out  1: sequencer idle, can accept.
- `seloutA`, `seloutB`  out  4: bank read selects.
- `cnstA`, `cnstB`  out  1: bank constant-source selects.
- `enrregA`, `enrregB`  out  1: bank read enables.
- `banq_outA`, `banq_outB`  in  DATA_W: bank read data, valid 1 cycle after enable.
- `aluA`, `aluB`  out  DATA_W: registered ALU operands.
- `opr`  out  5: ALU operation.
- `start`  out  1: ALU start pulse.
- `alu_done`  in  1: ALU completion.
- `alu_out`  in  DATA_W: ALU result.
- `regwen`  out  1: bank write enable.
- `selwreg`  out  4: bank write select.
- `endwreg`  out  2: bank write mode.
- `wdata`  out  DATA_W: write-back data.
- `busy`  out  1: high in every state except IDLE.
- `err`  out  2: sticky status. 00 ok, 01 timeout, 10 illegal.

## Operation
- Reset (`reset`==0 at a rising edge) forces:
  - state IDLE, `instr_ready`=1.
  - `start`, `regwen`, `enrregA/B`, `cnstA/B`, `busy` = 0.
  - `err`=00; all selects, `opr`, `endwreg` = 0.
  - `aluA`, `aluB`, `wdata` = 0.
- IDLE: `instr_ready`=1. Handshake fires when `instr_valid & instr_ready`.
  - On handshake the instruction is captured in an internal register and `err` is cleared to 00.
  - If the reserved bits are ≠0: `err`=10, stay IDLE, no bank/ALU activity.
  - Otherwise go to READ.
- READ (1 cycle): drive `seloutA`=srcA, `seloutB`=srcB, `cnstA/B` from fields, `enrregA/B`=1.
- LATCH (1 cycle): `aluA`<=`banq_outA`, `aluB`<=`banq_outB`; `opr` driven from the field.
- EXEC (1 cycle): `start`=1. The watchdog counter clears.
- WAIT: `alu_done` is sampled.
  - On `alu_done`: `wdata`<=`alu_out`, then go to WB if wb_en=1, else IDLE.
  - If the counter reaches `TIMEOUT_CYCLES` first: `err`=01, go to IDLE, no write.
- WB (1 cycle): `regwen`=1, `selwreg`=dst, `endwreg`=endw; then go to IDLE.
- `opr`, `aluA`, `aluB` hold from LATCH until the next handshake.
- `alu_done` is ignored outside WAIT, including in the EXEC cycle.
- Reset asserted in any state aborts the instruction. No `regwen` is issued on the following cycles.

## Timing
- Handshake at edge 0. Then:
  - READ at cycle 1, LATCH at cycle 2, `start` high in cycle 3.
  - If `alu_done` is first high in cycle d≥4, `regwen` is high in cycle d+1.
  - `instr_ready` returns high in cycle d+2.
- Minimum issue interval is 6 cycles (d=4).
- With wb_en=0, `instr_ready` is high in cycle d+1.
- Timeout: if there is no done in cycles 4..3+`TIMEOUT_CYCLES`, `instr_ready` is high in cycle 4+`TIMEOUT_CYCLES`.
- Illegal instruction: `err`=10 is visible cycle 1; `instr_ready` stays 1 throughout.
- `start`, `regwen`, `enrregA/B` are exactly one cycle wide.

## Structure
- Package `exec_pkg` holds:
  - the state enum (IDLE, READ, LATCH, EXEC, WAIT, WB)
  - instruction field offsets/widths
  - err codes (ERR_NONE, ERR_TIMEOUT, ERR_ILLEGAL)
- Sub-module `done_watchdog`: clear/enable inputs, `expired` output, parameter `TIMEOUT_CYCLES`.
- All other logic lives in the `exec_ctrl` FSM.

## Test plan
- Bank model with R1=0x10, R2=0x20, ALU sum model (done 2 cycles after start). Issue instr=0x206422 (sum, srcA=1, srcB=2, dst=3, wb_en=1) -> `start` in cycle 3, `regwen` in cycle 6 with `selwreg`=3, `wdata`=0x30, `err`=00.
- Same instruction with bit 21 cleared (0x006422) -> no `regwen`; `instr_ready` high in cycle 6; `wdata`=0x30.
- Instruction 0xC06422 (reserved bits set) -> `err`=10 at cycle 1; no `enrregA`/`start`/`regwen`; `instr_ready` stays 1.
- ALU model never asserts done, `TIMEOUT_CYCLES`=8 -> `err`=01, `instr_ready` high at cycle 12, no `regwen`. The next valid instruction clears `err` to 00.
- Pulse `reset` low in the WAIT cycle -> all outputs return to their reset values next cycle. A late `alu_done` produces no `regwen`.
- Back-to-back: `instr_valid` held high with 3 instructions (dst=3,4,5), ALU done at cycle 4 each -> handshakes every 6 cycles, three `regwen` pulses in order 3,4,5.
